// File: rtl/alu_pkg.sv
// Shared opcode encodings, checker FSM states and default widths for the ALU
// checker slice.
package alu_pkg;

  localparam int unsigned DEFAULT_DW = 16;
  localparam int unsigned DEFAULT_CW = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_ROL = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU model: recomputes the expected result of one
// operation so any checker can compare it against an observed result.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    imm,
  output logic [DW-1:0] result
);

  logic [2*DW-1:0] rot;

  always_comb begin
    // Rotate = upper half of the doubled word shifted left.
    rot    = {a, a} << imm;
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLL:  result = a << imm;
      OP_SRL:  result = a >> imm;
      OP_SRA:  result = $signed(a) >>> imm;
      OP_ROL:  result = rot[2*DW-1 -: DW];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Streaming ALU result checker: accepts operand/result beats, recomputes the
// expected value and accumulates mismatch statistics over a programmed run.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW,
  parameter int unsigned CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] expect_cnt,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [3:0]    in_imm,
  input  logic [DW-1:0] in_out,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] fail_idx,
  output logic [DW-1:0] fail_exp,
  output logic [DW-1:0] fail_got
);

  state_e        state;
  logic [CW-1:0] expect_q;
  logic [CW-1:0] acc_cnt;
  logic [CW-1:0] acc_inc;
  logic          accept;
  logic          start_ok;
  logic [DW-1:0] exp_val;

  logic          s1_valid;
  logic [DW-1:0] s1_exp;
  logic [DW-1:0] s1_got;
  logic [CW-1:0] s1_idx;
  logic          have_fail;

  alu_ref_model #(
    .DW(DW)
  ) u_ref (
    .op    (in_op),
    .a     (in_a),
    .b     (in_b),
    .imm   (in_imm),
    .result(exp_val)
  );

  assign accept   = in_valid & in_ready;
  assign acc_inc  = acc_cnt + CW'(1);
  assign start_ok = start & ((state == StIdle) | (state == StDone));
  assign pass     = done & (err_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      expect_q <= '0;
      acc_cnt  <= '0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start) begin
            expect_q <= expect_cnt;
            acc_cnt  <= '0;
            if (expect_cnt == '0) begin
              state    <= StDone;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= StRun;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
        end
        StRun: begin
          if (accept) begin
            acc_cnt <= acc_inc;
            if (acc_inc == expect_q) begin
              state    <= StDrain;
              in_ready <= 1'b0;
            end
          end
        end
        StDrain: begin
          // Wait for the last beat to leave stage 1 so err_cnt is final.
          if (!s1_valid) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= StIdle;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: register expected/observed pair with its run index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_exp   <= '0;
      s1_got   <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_exp <= exp_val;
        s1_got <= in_out;
        s1_idx <= acc_cnt;
      end
    end
  end

  // Stage 2: compare, count and capture the first failing vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt   <= '0;
      fail_idx  <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      have_fail <= 1'b0;
    end else if (start_ok) begin
      err_cnt   <= '0;
      fail_idx  <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      have_fail <= 1'b0;
    end else if (s1_valid && (s1_exp != s1_got)) begin
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + CW'(1);
      end
      if (!have_fail) begin
        have_fail <= 1'b1;
        fail_idx  <= s1_idx;
        fail_exp  <= s1_exp;
        fail_got  <= s1_got;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker with a transaction-level model that is
// compared against the DUT outputs on every falling clock edge.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] expect_cnt = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0]  in_imm = '0;
  logic [15:0] in_out = '0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [15:0] fail_idx;
  logic [15:0] fail_exp;
  logic [15:0] fail_got;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_result_checker #(
    .DW(16),
    .CW(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .expect_cnt(expect_cnt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_imm    (in_imm),
    .in_out    (in_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_idx  (fail_idx),
    .fail_exp  (fail_exp),
    .fail_got  (fail_got)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Golden result from plain integer arithmetic.
  function automatic logic [15:0] gold(input logic [2:0] op, input logic [15:0] a,
                                       input logic [15:0] b, input logic [3:0] imm);
    longint ia;
    longint ib;
    longint p;
    int     sa;
    logic [15:0] r;
    ia = longint'(a);
    ib = longint'(b);
    p  = longint'(1) << imm;
    case (op)
      3'd0: return 16'((ia + ib) % 65536);
      3'd1: return 16'((ia - ib + 65536) % 65536);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return 16'((ia * p) % 65536);
      3'd5: return 16'(ia / p);
      3'd6: begin
        sa = a[15] ? int'(ia) - 65536 : int'(ia);
        sa = sa >>> imm;
        return 16'(sa & 32'h0000_ffff);
      end
      default: begin
        r = a;
        for (int i = 0; i < int'(imm); i++) r = {r[14:0], r[15]};
        return r;
      end
    endcase
  endfunction

  // Transaction model: accepted beats timestamped by edge number.
  typedef struct {
    int          k;
    logic [15:0] e;
    logic [15:0] g;
    int          idx;
  } beat_t;

  beat_t beats_q[$];
  bit    m_armed = 1'b0;
  int    m_cnt = 0;
  int    m_beats = 0;
  int    m_last = 0;
  int    cyc = 0;

  function automatic bit m_ready();
    return m_armed && (m_beats < m_cnt);
  endfunction

  function automatic bit m_done();
    return m_armed && (m_beats == m_cnt) && ((m_cnt == 0) || (cyc >= m_last + 2));
  endfunction

  function automatic bit m_busy();
    return m_armed && !m_done();
  endfunction

  initial begin
    bit acc;
    bit st;
    forever begin
      @(posedge clk);
      acc = in_valid && m_ready();
      st  = start && !m_busy();
      cyc++;
      if (!rst_n) begin
        m_armed = 1'b0;
        m_cnt   = 0;
        m_beats = 0;
        m_last  = 0;
        beats_q.delete();
      end else if (acc) begin
        beats_q.push_back('{k: cyc, e: gold(in_op, in_a, in_b, in_imm), g: in_out,
                            idx: m_beats});
        m_beats++;
        m_last = cyc;
      end else if (st) begin
        m_armed = 1'b1;
        m_cnt   = int'(expect_cnt);
        m_beats = 0;
        beats_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    int          e_err;
    logic [15:0] e_idx;
    logic [15:0] e_exp;
    logic [15:0] e_got;
    bit          found;
    e_err = 0;
    e_idx = '0;
    e_exp = '0;
    e_got = '0;
    found = 1'b0;
    foreach (beats_q[i]) begin
      if (beats_q[i].k < cyc && beats_q[i].e != beats_q[i].g) begin
        if (e_err < 65535) e_err++;
        if (!found) begin
          found = 1'b1;
          e_idx = 16'(beats_q[i].idx);
          e_exp = beats_q[i].e;
          e_got = beats_q[i].g;
        end
      end
    end
    check("in_ready", 32'(in_ready), 32'(m_ready()));
    check("busy", 32'(busy), 32'(m_busy()));
    check("done", 32'(done), 32'(m_done()));
    check("pass", 32'(pass), 32'(m_done() && e_err == 0));
    check("err_cnt", 32'(err_cnt), 32'(e_err));
    check("fail_idx", 32'(fail_idx), 32'(e_idx));
    check("fail_exp", 32'(fail_exp), 32'(e_exp));
    check("fail_got", 32'(fail_got), 32'(e_got));
  end

  logic [2:0]  v_op[8];
  logic [15:0] v_a[8];
  logic [15:0] v_b[8];
  logic [3:0]  v_imm[8];
  logic [15:0] v_res[8];

  task automatic pulse_start(input int n);
    @(negedge clk);
    start      = 1'b1;
    expect_cnt = 16'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int i, input logic [15:0] got);
    int n;
    @(negedge clk);
    in_op    = v_op[i];
    in_a     = v_a[i];
    in_b     = v_b[i];
    in_imm   = v_imm[i];
    in_out   = got;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", 32'(done), 32'd1);
  endtask

  task automatic run8(input logic [7:0] mask);
    pulse_start(8);
    for (int i = 0; i < 8; i++) send(i, v_res[i] ^ {15'd0, mask[i]});
    wait_done();
  endtask

  initial begin
    v_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    v_a   = '{16'h130f, 16'hfedc, 16'hcdef, 16'hcdef, 16'hb042, 16'hb042, 16'hb742, 16'hb742};
    v_b   = '{16'h5701, 16'hab98, 16'h89ab, 16'h89ab, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    v_imm = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd4, 4'd4};
    v_res = '{16'h6a10, 16'h5344, 16'h89ab, 16'hcdef, 16'h6084, 16'h5821, 16'hfb74, 16'h742b};

    for (int i = 0; i < 8; i++) begin
      check($sformatf("gold[%0d]", i), 32'(gold(v_op[i], v_a[i], v_b[i], v_imm[i])),
            32'(v_res[i]));
    end
    check("gold rol0", 32'(gold(3'd7, 16'h8001, 16'h0, 4'd0)), 32'h8001);
    check("gold sra0", 32'(gold(3'd6, 16'h8001, 16'h0, 4'd0)), 32'h8001);

    repeat (3) @(negedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;

    // Clean run.
    run8(8'h00);
    check("run1 pass", 32'(pass), 32'd1);
    check("run1 err_cnt", 32'(err_cnt), 32'd0);

    // Vector 5 corrupted to 5820.
    run8(8'b0010_0000);
    check("run2 err_cnt", 32'(err_cnt), 32'd1);
    check("run2 fail_idx", 32'(fail_idx), 32'd5);
    check("run2 fail_exp", 32'(fail_exp), 32'h5821);
    check("run2 fail_got", 32'(fail_got), 32'h5820);
    check("run2 pass", 32'(pass), 32'd0);

    // Vectors 2 and 6 corrupted.
    run8(8'b0100_0100);
    check("run3 err_cnt", 32'(err_cnt), 32'd2);
    check("run3 fail_idx", 32'(fail_idx), 32'd2);
    check("run3 fail_got", 32'(fail_got), 32'h89aa);

    // in_valid toggling every other cycle, 4 beats.
    pulse_start(4);
    for (int i = 0; i < 4; i++) begin
      send(i, v_res[i]);
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    check("tog done E", 32'(done), 32'd0);
    @(negedge clk);
    check("tog done E+1", 32'(done), 32'd0);
    @(negedge clk);
    check("tog done E+2", 32'(done), 32'd1);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("tog in_ready after", 32'(in_ready), 32'd0);
    check("tog pass", 32'(pass), 32'd1);
    in_valid = 1'b0;

    // Zero-length run.
    pulse_start(0);
    check("zero done", 32'(done), 32'd1);
    check("zero pass", 32'(pass), 32'd1);

    // start during RUN is ignored.
    pulse_start(4);
    send(0, v_res[0]);
    send(1, v_res[1]);
    pulse_start(9);
    send(2, v_res[2]);
    send(3, 16'hdead);
    wait_done();
    check("ign err_cnt", 32'(err_cnt), 32'd1);
    check("ign fail_idx", 32'(fail_idx), 32'd3);

    // Reset in the middle of a run.
    pulse_start(4);
    send(0, 16'h0bad);
    send(1, v_res[1]);
    @(negedge clk);
    check("pre-reset err_cnt", 32'(err_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
    check("rst fail_got", 32'(fail_got), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run8(8'h00);
    check("post-reset pass", 32'(pass), 32'd1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
